// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared types for the registered bitwise logic unit.
// Holds the operation and FSM state encodings used by logic_unit_pipe and logic_op_core.
`timescale 1ns/1ps

package logic_unit_pkg;

   // Operation select, encoded exactly as driven on in_op.
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   // Pipe control states: waiting, folding a burst, holding a result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHAIN = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

   localparam int OP_W = 3;

endpackage : logic_unit_pkg

// File: rtl/logic_op_core.sv
// logic_op_core: purely combinational W-bit bitwise operator y = op(x, z).
// Unary ops (NOT, PASS) act on x only; result bit i depends only on operand bit i.
`timescale 1ns/1ps

module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [OP_W-1:0] op_i,
   input  logic [W-1:0]    x_i,
   input  logic [W-1:0]    z_i,
   output logic [W-1:0]    y_o
);

   op_e op;

   assign op = op_e'(op_i);

   // Select the bitwise function of the two operands.
   always_comb begin
      // NOTE: y_o gets a default before the case so no latch can be inferred.
      y_o = '0;
      case (op)
         OP_AND:  y_o = x_i & z_i;
         OP_OR:   y_o = x_i | z_i;
         OP_NAND: y_o = ~(x_i & z_i);
         OP_NOR:  y_o = ~(x_i | z_i);
         OP_XOR:  y_o = x_i ^ z_i;
         OP_XNOR: y_o = ~(x_i ^ z_i);
         OP_NOT:  y_o = ~x_i;
         OP_PASS: y_o = x_i;
         default: y_o = '0;
      endcase
   end

endmodule : logic_op_core

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered W-bit logic unit with valid/ready on both sides,
// a one-entry output register and chain mode that folds a burst of operands into one result.
// Optional feature macro LOGIC_UNIT_FLAGS_EN adds registered out_zero / out_parity flags.
`timescale 1ns/1ps

module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter  int W         = 8,
   parameter  int MAX_CHAIN = 16,
   localparam int CW        = $clog2(MAX_CHAIN + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic [OP_W-1:0] in_op,
   input  logic            in_chain,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_y,
   output logic [CW-1:0]   out_beats,
`ifdef LOGIC_UNIT_FLAGS_EN
   output logic            out_zero,
   output logic            out_parity,
`endif
   output logic            out_trunc
);

   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_y_q, out_y_d;
   logic [CW-1:0] out_beats_q, out_beats_d;
   logic          out_trunc_q, out_trunc_d;

   logic          accept;
   logic          first_beat;
   op_e           beat_op;
   logic          unary_op;
   logic [W-1:0]  core_x, core_z, core_y;
   logic [CW-1:0] cnt_next;
   logic          hit_max;
   logic          terminate;
   logic          trunc_now;
   logic          load_out;

   // Ready depends only on state and out_ready so upstream never sees a loop through in_valid.
   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_CHAIN) ||
                     ((state_q == ST_OUT) && out_ready);
   assign accept   = in_valid && in_ready;

   // Any beat not arriving in CHAIN opens a new result and uses its own op and operand B.
   assign first_beat = (state_q != ST_CHAIN);
   assign beat_op    = first_beat ? op_e'(in_op) : op_q;
   assign unary_op   = (beat_op == OP_NOT) || (beat_op == OP_PASS);

   // First beat folds (in_a, in_b); later beats fold (acc, in_a), unary ops see in_a directly.
   assign core_x = (first_beat || unary_op) ? in_a : acc_q;
   assign core_z = first_beat ? in_b : in_a;

   logic_op_core #(
      .W (W)
   ) u_core (
      .op_i (beat_op),
      .x_i  (core_x),
      .z_i  (core_z),
      .y_o  (core_y)
   );

   // Beat count and end-of-result decision for the beat currently offered.
   assign cnt_next  = first_beat ? CW'(1) : (cnt_q + CW'(1));
   assign hit_max   = (cnt_next == CW'(MAX_CHAIN));
   assign terminate = !in_chain || in_last || hit_max;
   assign trunc_now = in_chain && !in_last && hit_max;
   assign load_out  = accept && terminate;

   // Next-state logic: fold accepted beats, publish finished results, retire taken results.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_beats_d = out_beats_q;
      out_trunc_d = out_trunc_q;

      if (accept) begin
         acc_d = core_y;
         if (first_beat) begin
            op_d = op_e'(in_op);
         end
         if (terminate) begin
            state_d     = ST_OUT;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_y_d     = core_y;
            out_beats_d = cnt_next;
            out_trunc_d = trunc_now;
         end else begin
            // A burst opened while leaving OUT retires the old result; out_y keeps its value.
            state_d     = ST_CHAIN;
            cnt_d       = cnt_next;
            out_valid_d = 1'b0;
         end
      end else if ((state_q == ST_OUT) && out_ready) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end
   end

   // State and output registers; reset discards any partial chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_beats_q <= '0;
         out_trunc_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_beats_q <= out_beats_d;
         out_trunc_q <= out_trunc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_beats = out_beats_q;
   assign out_trunc = out_trunc_q;

`ifdef LOGIC_UNIT_FLAGS_EN
   logic out_zero_q, out_parity_q;

   // Flags load only together with a new result so they stay aligned with out_y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_zero_q   <= 1'b0;
         out_parity_q <= 1'b0;
      end else if (load_out) begin
         out_zero_q   <= (core_y == '0);
         out_parity_q <= ^core_y;
      end
   end

   assign out_zero   = out_zero_q;
   assign out_parity = out_parity_q;
`else
   logic unused_load_out;
   assign unused_load_out = load_out;
`endif

endmodule : logic_unit_pipe
